// File: rtl/hdr_stream_aligner.sv
// hdr_stream_aligner: pairs the live exposure stream with the stored exposure
// stream. The stored stream is buffered in a FIFO and paced by asi_snk_1_ready_o.
// Define HDR_ALIGN_STATS_EN to compile in the alignment statistics counters on stats_o.
module hdr_stream_aligner #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  asi_snk_0_valid_i,
  input  logic [DATA_WIDTH-1:0] asi_snk_0_data_i,
  input  logic                  asi_snk_0_startofpacket_i,
  input  logic                  asi_snk_0_endofpacket_i,
  input  logic                  asi_snk_1_valid_i,
  input  logic [DATA_WIDTH-1:0] asi_snk_1_data_i,
  input  logic                  asi_snk_1_startofpacket_i,
  input  logic                  asi_snk_1_endofpacket_i,
  output logic                  asi_snk_1_ready_o,
  output logic                  aso_src_valid_o,
  output logic                  aso_src_startofpacket_o,
  output logic                  aso_src_endofpacket_o,
  output logic [DATA_WIDTH-1:0] aso_src_data0_o,
  output logic [DATA_WIDTH-1:0] aso_src_data1_o,
  output logic                  underflow_o,
  output logic                  misalign_o,
  input  logic                  clear_i,
  output logic [47:0]           stats_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int WW = DATA_WIDTH + 2;
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {SYNC, ARMED, RUN} state_t;
  state_t state_q, state_d;

  // Stored words are kept as {eop, sop, data}.
  logic [WW-1:0]         mem [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_ptr_nx;
  logic [AW:0]           count_q, count_d;
  logic                  ready_q, ready_d;
  logic                  push, pop, fifo_empty;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_sop, head_eop, next_sop;

  logic                  valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
  logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic                  underflow_q, underflow_d, misalign_q, misalign_d;
  logic                  uf_event, ma_event, frame_event;

  assign push       = asi_snk_1_valid_i && ready_q;
  assign fifo_empty = (count_q == '0);
  assign rd_ptr_nx  = rd_ptr_q + AW'(1);
  // Head is read asynchronously: the FSM needs its sop/eop in the same cycle.
  assign head_data  = mem[rd_ptr_q][DATA_WIDTH-1:0];
  assign head_sop   = mem[rd_ptr_q][DATA_WIDTH];
  assign head_eop   = mem[rd_ptr_q][DATA_WIDTH+1];
  assign next_sop   = mem[rd_ptr_nx][DATA_WIDTH];

  // FIFO storage write port; contents need no reset because count gates reads.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {asi_snk_1_endofpacket_i, asi_snk_1_startofpacket_i, asi_snk_1_data_i};
  end

  // Alignment FSM: decides pops, the paired stored word and fault events.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    uf_event    = 1'b0;
    ma_event    = 1'b0;
    frame_event = 1'b0;
    valid_d     = asi_snk_0_valid_i;
    sop_d       = asi_snk_0_valid_i && asi_snk_0_startofpacket_i;
    eop_d       = asi_snk_0_valid_i && asi_snk_0_endofpacket_i;
    data0_d     = asi_snk_0_data_i;
    data1_d     = asi_snk_0_data_i;
    case (state_q)
      SYNC: begin
        if (!fifo_empty) begin
          if (head_sop) state_d = ARMED;
          else          pop     = 1'b1;
        end
      end
      ARMED: begin
        if (asi_snk_0_valid_i && asi_snk_0_startofpacket_i && !fifo_empty) begin
          pop     = 1'b1;
          data1_d = head_data;
          state_d = RUN;
        end
      end
      RUN: begin
        if (asi_snk_0_valid_i) begin
          if (fifo_empty) begin
            uf_event = 1'b1;
            state_d  = SYNC;
          end else begin
            pop     = 1'b1;
            data1_d = head_data;
            if (asi_snk_0_endofpacket_i != head_eop) begin
              ma_event = 1'b1;
              state_d  = SYNC;
            end else if (asi_snk_0_endofpacket_i) begin
              frame_event = 1'b1;
              // The word behind the popped head only exists if at least two were held.
              state_d = (count_q > (AW+1)'(1) && next_sop) ? ARMED : SYNC;
            end
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  // FIFO bookkeeping and sticky fault flags (a new fault beats a clear).
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);
    ready_d     = (count_d < DEPTH_CNT);
    underflow_d = clear_i ? 1'b0 : underflow_q;
    misalign_d  = clear_i ? 1'b0 : misalign_q;
    if (uf_event) underflow_d = 1'b1;
    if (ma_event) misalign_d  = 1'b1;
  end

  // State, FIFO control and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= SYNC;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b0;
      valid_q     <= 1'b0;
      sop_q       <= 1'b0;
      eop_q       <= 1'b0;
      data0_q     <= '0;
      data1_q     <= '0;
      underflow_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      sop_q       <= sop_d;
      eop_q       <= eop_d;
      data0_q     <= data0_d;
      data1_q     <= data1_d;
      underflow_q <= underflow_d;
      misalign_q  <= misalign_d;
    end
  end

  assign asi_snk_1_ready_o       = ready_q;
  assign aso_src_valid_o         = valid_q;
  assign aso_src_startofpacket_o = sop_q;
  assign aso_src_endofpacket_o   = eop_q;
  assign aso_src_data0_o         = data0_q;
  assign aso_src_data1_o         = data1_q;
  assign underflow_o             = underflow_q;
  assign misalign_o              = misalign_q;

`ifdef HDR_ALIGN_STATS_EN
  logic [15:0] frames_q, frames_d, uf_cnt_q, uf_cnt_d, ma_cnt_q, ma_cnt_d;

  // Saturating event counters; an event in the clear cycle counts as the first.
  always_comb begin
    frames_d = clear_i ? 16'd0 : frames_q;
    uf_cnt_d = clear_i ? 16'd0 : uf_cnt_q;
    ma_cnt_d = clear_i ? 16'd0 : ma_cnt_q;
    if (frame_event && frames_d != 16'hFFFF) frames_d = frames_d + 16'd1;
    if (uf_event    && uf_cnt_d != 16'hFFFF) uf_cnt_d = uf_cnt_d + 16'd1;
    if (ma_event    && ma_cnt_d != 16'hFFFF) ma_cnt_d = ma_cnt_d + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      frames_q <= '0;
      uf_cnt_q <= '0;
      ma_cnt_q <= '0;
    end else begin
      frames_q <= frames_d;
      uf_cnt_q <= uf_cnt_d;
      ma_cnt_q <= ma_cnt_d;
    end
  end

  assign stats_o = {ma_cnt_q, uf_cnt_q, frames_q};
`else
  logic unused_frame_event;
  assign unused_frame_event = frame_event;
  assign stats_o = '0;
`endif
endmodule

// File: doc/hdr_stream_aligner.md
# hdr_stream_aligner

Aligns the live exposure stream with the stored exposure stream read back from the frame buffer, so that `wrp_HDR_algorithm` receives one pixel pair per cycle with common valid/startofpacket/endofpacket. Sits directly upstream of the HDR merge stage. The live stream cannot be stalled; the stored stream is buffered in an internal FIFO and back-pressured with `ready`. The block enforces frame alignment on startofpacket and reports underflow and alignment faults.

## Interface
- `DATA_WIDTH`, 32, pixel word width of both streams.
- `DEPTH`, 64, stored-stream FIFO depth in words; power of two, ≥ 4.
- `clk` input 1: single clock for all logic.
- `reset_n` input 1: synchronous, active-low reset.
- `asi_snk_0_valid_i` input 1: live stream valid; has no ready and is never stalled.
- `asi_snk_0_data_i` input DATA_WIDTH: live pixel.
- `asi_snk_0_startofpacket_i` / `asi_snk_0_endofpacket_i` input 1 each: live frame markers.
- `asi_snk_1_valid_i` input 1: stored stream valid.
- `asi_snk_1_data_i` input DATA_WIDTH: stored pixel.
- `asi_snk_1_startofpacket_i` / `asi_snk_1_endofpacket_i` input 1 each: stored frame markers.
- `asi_snk_1_ready_o` output 1: stored-stream ready.
- `aso_src_valid_o` / `aso_src_startofpacket_o` / `aso_src_endofpacket_o` output 1 each: aligned control.
- `aso_src_data0_o` output DATA_WIDTH: live pixel; drives `asi_snk_0_data_i` of the merge stage.
- `aso_src_data1_o` output DATA_WIDTH: paired stored pixel; drives `asi_snk_1_data_i` of the merge stage.
- `underflow_o` output 1: sticky; a live beat found no stored word.
- `misalign_o` output 1: sticky; live and stored eop disagreed.
- `clear_i` input 1: clears both sticky flags and the statistics counters.

## Operation
- The FIFO stores {eop, sop, data} (DATA_WIDTH+2 bits) and holds a count 0..DEPTH.
- Push occurs when `asi_snk_1_valid_i && asi_snk_1_ready_o`.
- Pointers are log2(DEPTH) bits and wrap naturally.
- `asi_snk_1_ready_o` = registered (count < DEPTH).
- On a cycle with both push and pop, count is unchanged.
- When the FIFO is full, ready is low; a pop raises ready on the next cycle.
- FSM states: SYNC, ARMED, RUN.
- SYNC: pop and discard FIFO head words until the head has sop set, then go to ARMED. Live beats in SYNC are output with data1 = data0.
- ARMED: the FIFO head is held.
  - Live beat with sop: pop the head, output the pair, go to RUN.
  - Live beat without sop: output with data1 = data0, no pop.
- RUN: each live beat pops one word and outputs the pair.
  - FIFO empty on a live beat: set `underflow_o`, output data1 = data0, go to SYNC.
  - Live eop ≠ popped eop: set `misalign_o`, output the pair, go to SYNC.
  - Live eop together with popped eop: go to ARMED if the next head has sop, else SYNC.
- Output control (sop/eop/valid) always follows the live stream; the stored markers are never forwarded.
- Sticky flags clear only on `clear_i` or reset. If `clear_i` and a new fault occur in the same cycle, the fault wins.

## Timing
- Latency is 1 cycle: live beat at cycle N → outputs registered at N+1.
- Throughput is one pair per cycle sustained.
- FIFO write-to-readable latency is 1 cycle. A word pushed at N can be popped by a live beat at N+1 or later.
- Reset values: all outputs 0 except `asi_snk_1_ready_o`, which is 0 during reset and 1 on the first cycle after release. FSM = SYNC, FIFO empty.
- Reset asserted mid-frame flushes the FIFO and drops any in-flight output on the next edge.

## Configuration
- `HDR_ALIGN_STATS_EN`, when defined, compiles in three 16-bit saturating counters:
  - frames aligned: RUN exits on a matched eop.
  - underflow events.
  - misalign events.
- With the macro, the counters are readable on output `stats_o` [47:0] = {misalign, underflow, frames}, cleared by `clear_i` and reset.
- Without it, `stats_o` is present and tied to 0, and no counter logic is synthesized.

## Test plan
- **Prefill and match:** prefill 16 stored words (sop on word 0, eop on word 15), then drive a 16-beat live frame → 16 output pairs with data1 = stored 0..15, sop/eop on beats 0/15, latency 1, no flags.
- **Backpressure:** drive the stored stream continuously with no live traffic → ready drops after DEPTH=64 pushes and count = 64. One live pop → ready high again on the following cycle.
- **Underflow:** 4 stored words, then a 6-beat live frame → beats 0-3 paired; beat 4 gives data1 = data0, `underflow_o` = 1, FSM returns to SYNC.
- **Misalignment:** stored eop at word 7, live eop at beat 9 → `misalign_o` set at the output of beat 7. The next stored sop word is re-acquired in SYNC, and the next live frame aligns.
- **Garbage before sop:** 3 non-sop stored words ahead of the sop word → all 3 are discarded, and the first live sop pairs with the sop word.
- **Reset mid-frame:** assert `reset_n` = 0 at live beat 5 → next cycle all outputs 0 and FIFO empty; the first frame after release aligns cleanly.
